// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bundle of pipeline, MDU, scoreboard-query and regfile-port signals
interface regfile_wb_arbiter_if;
   logic        pipe_we;
   logic [4:0]  pipe_wn;
   logic [31:0] pipe_d;
   logic        mdu_valid;
   logic [4:0]  mdu_wn;
   logic [31:0] mdu_d;
   logic        mdu_ready;
   logic        issue_valid;
   logic [4:0]  issue_wn;
   logic        issue_ok;
   logic [4:0]  q_rna;
   logic [4:0]  q_rnb;
   logic        busy_a;
   logic        busy_b;
   logic        pipe_hold;
   logic        rf_we;
   logic [4:0]  rf_wn;
   logic [31:0] rf_d;
   logic        err;
   modport slave (
      input  pipe_we, pipe_wn, pipe_d, mdu_valid, mdu_wn, mdu_d, issue_valid, issue_wn, q_rna, q_rnb,
      output mdu_ready, issue_ok, busy_a, busy_b, pipe_hold, rf_we, rf_wn, rf_d, err
   );
   modport master (
      output pipe_we, pipe_wn, pipe_d, mdu_valid, mdu_wn, mdu_d, issue_valid, issue_wn, q_rna, q_rnb,
      input  mdu_ready, issue_ok, busy_a, busy_b, pipe_hold, rf_we, rf_wn, rf_d, err
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between pipeline writeback and buffered MDU results
module regfile_wb_arbiter #(
   parameter int DEPTH  = 2,
   parameter int STARVE = 8
) (
   input logic clk,
   input logic clr,
   regfile_wb_arbiter_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int AW1 = AW + 1;
   localparam int GW  = $clog2(STARVE + 1);
   localparam logic [AW:0]   FULL_C    = AW1'(DEPTH);
   localparam logic [GW-1:0] STARVE_C  = GW'(STARVE);
   localparam logic [GW-1:0] STARVE_M1 = GW'(STARVE - 1);
   logic [4:0]    wn_q [DEPTH];
   logic [31:0]   d_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   pend_q, pend_d;
   logic [GW-1:0] age_q, age_d;
   logic          hold_q, hold_d, err_q, err_d;
   logic          pipe_eff, empty, full, pop, push, sel_pipe, sel_fifo;
   logic [4:0]    head_wn;
   logic [31:0]   head_d;
   // port mux, FIFO control, scoreboard and starvation next-state
   always_comb begin
      pipe_eff      = bus.pipe_we && bus.pipe_wn != 5'd0;
      empty         = cnt_q == '0;
      full          = cnt_q == FULL_C;
      head_wn       = wn_q[rd_q];
      head_d        = d_q[rd_q];
      pop           = !empty && !pipe_eff;
      bus.mdu_ready = !full && !clr;
      push          = bus.mdu_valid && bus.mdu_ready;
      sel_pipe      = !clr && pipe_eff;
      sel_fifo      = !clr && !pipe_eff && !empty && head_wn != 5'd0;
      bus.rf_we     = sel_pipe || sel_fifo;
      bus.rf_wn     = sel_pipe ? bus.pipe_wn : sel_fifo ? head_wn : 5'd0;
      bus.rf_d      = sel_pipe ? bus.pipe_d : sel_fifo ? head_d : 32'd0;
      bus.issue_ok  = bus.issue_valid && (bus.issue_wn == 5'd0 || !pend_q[bus.issue_wn]);
      bus.busy_a    = pend_q[bus.q_rna];
      bus.busy_b    = pend_q[bus.q_rnb];
      bus.pipe_hold = hold_q;
      bus.err       = err_q;
      pend_d        = pend_q;
      if (pop && head_wn != 5'd0) pend_d[head_wn] = 1'b0;
      if (bus.issue_ok && bus.issue_wn != 5'd0) pend_d[bus.issue_wn] = 1'b1;
      pend_d[0]     = 1'b0;
      rd_d          = pop ? rd_q + 1'b1 : rd_q;
      wr_d          = push ? wr_q + 1'b1 : wr_q;
      cnt_d         = cnt_q + AW1'(push) - AW1'(pop);
      age_d         = (empty || pop) ? '0 : (age_q == STARVE_C) ? age_q : age_q + 1'b1;
      hold_d        = pop ? 1'b0 : (!empty && age_q == STARVE_M1) ? 1'b1 : hold_q;
      err_d         = err_q || (pipe_eff && hold_q) || (pipe_eff && pend_q[bus.pipe_wn])
                      || (push && bus.mdu_wn != 5'd0 && !pend_q[bus.mdu_wn]);
   end
   // FIFO storage; entries are only meaningful between rd and wr pointers
   always_ff @(posedge clk) begin
      if (push) begin
         wn_q[wr_q] <= bus.mdu_wn;
         d_q[wr_q]  <= bus.mdu_d;
      end
   end
   // control state, cleared asynchronously by clr
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         pend_q <= '0;
         age_q  <= '0;
         hold_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         age_q  <= age_d;
         hold_q <= hold_d;
         err_q  <= err_d;
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of port arbitration, scoreboard, starvation hold and error flag
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic clr;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [36:0] exp_q [$];
   always #5 clk = ~clk;
   regfile_wb_arbiter_if bus ();
   regfile_wb_arbiter #(.DEPTH(2), .STARVE(8)) dut (.clk(clk), .clr(clr), .bus(bus));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic exp_w(input logic [4:0] wn, input logic [31:0] d);
      exp_q.push_back({wn, d});
   endtask
   task automatic idle();
      bus.pipe_we = 0; bus.pipe_wn = 0; bus.pipe_d = 0;
      bus.mdu_valid = 0; bus.mdu_wn = 0; bus.mdu_d = 0;
      bus.issue_valid = 0; bus.issue_wn = 0; bus.q_rna = 0; bus.q_rnb = 0;
   endtask
   task automatic pipe(input logic we, input logic [4:0] wn, input logic [31:0] d);
      bus.pipe_we = we; bus.pipe_wn = wn; bus.pipe_d = d;
      if (we && wn != 0 && !clr) exp_w(wn, d);
   endtask
   task automatic mdu(input logic v, input logic [4:0] wn, input logic [31:0] d);
      bus.mdu_valid = v; bus.mdu_wn = wn; bus.mdu_d = d;
   endtask
   task automatic mid();
      logic [36:0] e;
      @(negedge clk);
      if (bus.rf_we) begin
         if (exp_q.size() == 0) chk("rf_spurious", bus.rf_we, 0);
         else begin
            e = exp_q.pop_front();
            chk("rf_write", {bus.rf_wn, bus.rf_d}, e);
         end
      end
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [4:0] wn);
      bus.issue_valid = 1; bus.issue_wn = wn;
      mid(); chk("issue_ok", bus.issue_ok, 1); nxt();
      bus.issue_valid = 0; bus.issue_wn = 0;
   endtask
   initial begin
      clr = 1;
      idle();
      bus.issue_valid = 1; bus.issue_wn = 3; bus.pipe_we = 1; bus.pipe_wn = 5;
      mid();
      chk("rst_ready", bus.mdu_ready, 0); chk("rst_rf_we", bus.rf_we, 0);
      chk("rst_hold", bus.pipe_hold, 0); chk("rst_err", bus.err, 0); chk("rst_issue_ok", bus.issue_ok, 1);
      nxt();
      clr = 0;
      idle();
      pipe(1, 5, 32'hDEADBEEF); mid(); chk("pipe_we", bus.rf_we, 1); nxt();
      pipe(1, 0, 32'h55); mid(); chk("pipe_x0", bus.rf_we, 0); chk("err_clean", bus.err, 0); nxt();
      pipe(0, 0, 0);
      issue(7);
      bus.issue_valid = 1; bus.issue_wn = 7; bus.q_rna = 7; mdu(1, 7, 32'h1234);
      mid();
      chk("reissue", bus.issue_ok, 0); chk("busy_a7", bus.busy_a, 1); chk("busy_b0", bus.busy_b, 0);
      chk("ready", bus.mdu_ready, 1); chk("no_bypass", bus.rf_we, 0);
      nxt();
      idle(); bus.q_rna = 7; exp_w(7, 32'h1234);
      mid(); chk("mdu_we", bus.rf_we, 1); chk("busy_during", bus.busy_a, 1); nxt();
      mid(); chk("busy_clear", bus.busy_a, 0); chk("idle_we", bus.rf_we, 0); nxt();
      idle();
      issue(9);
      pipe(1, 1, 32'h100); mdu(1, 9, 32'h99); mid(); nxt();
      mdu(0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         pipe(1, 1, 32'h200 + k); mid(); chk("hold_low", bus.pipe_hold, 0); nxt();
      end
      pipe(0, 0, 0); exp_w(9, 32'h99);
      mid(); chk("hold_high", bus.pipe_hold, 1); chk("drain_we", bus.rf_we, 1); nxt();
      mid(); chk("hold_drop", bus.pipe_hold, 0); chk("starve_err", bus.err, 0); nxt();
      issue(10);
      issue(11);
      pipe(1, 2, 32'h300); mdu(1, 10, 32'hA0); mid(); chk("fill0_ready", bus.mdu_ready, 1); nxt();
      pipe(1, 2, 32'h301); mdu(1, 11, 32'hB0); mid(); chk("fill1_ready", bus.mdu_ready, 1); nxt();
      pipe(1, 2, 32'h302); mdu(1, 12, 32'hC0); mid(); chk("full_ready", bus.mdu_ready, 0); nxt();
      pipe(0, 0, 0); exp_w(10, 32'hA0); mid(); chk("pop_ready", bus.mdu_ready, 0); nxt();
      mdu(0, 0, 0); exp_w(11, 32'hB0); mid(); chk("freed_ready", bus.mdu_ready, 1); nxt();
      mid(); chk("drained", bus.rf_we, 0); chk("fill_err", bus.err, 0); nxt();
      issue(13);
      pipe(1, 13, 32'h13); mid(); nxt();
      pipe(0, 0, 0); mid(); chk("err_pend", bus.err, 1); nxt();
      mid(); chk("err_sticky", bus.err, 1); nxt();
      clr = 1; bus.pipe_we = 1; bus.pipe_wn = 4;
      mid(); chk("clr_nowrite", bus.rf_we, 0); chk("clr_err", bus.err, 0); nxt();
      clr = 0; bus.pipe_we = 0; bus.pipe_wn = 0; bus.q_rna = 13;
      mid(); chk("clr_pend", bus.busy_a, 0); nxt();
      mdu(1, 20, 32'h20); mid(); chk("b_ready", bus.mdu_ready, 1); nxt();
      mdu(0, 0, 0); exp_w(20, 32'h20);
      mid(); chk("err_push", bus.err, 1); chk("b_we", bus.rf_we, 1); nxt();
      clr = 1; mid(); nxt(); clr = 0;
      issue(21);
      issue(22);
      for (int k = 0; k < 9; k++) begin
         pipe(1, 3, 32'h400 + k);
         if (k < 2) mdu(1, 5'(21 + k), 32'h21 + k); else mdu(0, 0, 0);
         mid(); chk("c_hold_low", bus.pipe_hold, 0); nxt();
      end
      pipe(1, 3, 32'h500); mid(); chk("c_hold", bus.pipe_hold, 1); nxt();
      pipe(0, 0, 0); exp_w(21, 32'h21);
      mid(); chk("err_hold", bus.err, 1); chk("c_we", bus.rf_we, 1); nxt();
      clr = 1; bus.q_rnb = 22;
      mid(); chk("mid_clr_we", bus.rf_we, 0); chk("mid_clr_ready", bus.mdu_ready, 0); chk("mid_clr_hold", bus.pipe_hold, 0); nxt();
      clr = 0;
      mid();
      chk("post_clr_we", bus.rf_we, 0); chk("post_clr_busy", bus.busy_b, 0);
      chk("post_clr_err", bus.err, 0); chk("post_clr_ready", bus.mdu_ready, 1);
      nxt();
      chk("exp_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
